// File: rtl/pix_buff_wr_sched_if.sv
// Bundle of requester pixel streams and FIFO write port for the pixel
// prefetch write scheduler; slave is the scheduler, master is its environment.
interface pix_buff_wr_sched_if #(
  parameter int N_REQ        = 2,
  parameter int PIX_W        = 24,
  parameter int PIX_PER_WORD = 10,
  parameter int DATA_W       = PIX_W * PIX_PER_WORD
);
  localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*PIX_W-1:0] req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_ready;
  logic [GID_W-1:0]       grant_id;
  logic                   busy;
  logic                   fifo_wr_en;
  logic [DATA_W-1:0]      fifo_wr_data;
  logic                   fifo_wr_vld;

  modport slave (
    input  req_valid, req_data, req_last, fifo_wr_vld,
    output req_ready, grant_id, busy, fifo_wr_en, fifo_wr_data
  );

  modport master (
    output req_valid, req_data, req_last, fifo_wr_vld,
    input  req_ready, grant_id, busy, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/pix_buff_wr_sched.sv
// Round-robin, one-line-per-grant write scheduler: packs requester pixels into
// FIFO words and pushes them through a single output register.
module pix_buff_wr_sched #(
  parameter int N_REQ        = 2,
  parameter int PIX_W        = 24,
  parameter int PIX_PER_WORD = 10,
  parameter int DATA_W       = PIX_W * PIX_PER_WORD
) (
  input  logic                clk,
  input  logic                rst_n,
  pix_buff_wr_sched_if.slave  bus
);
  localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] XFER  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [GID_W-1:0]  rr_ptr;
  logic [GID_W-1:0]  grant_id;
  logic [GID_W-1:0]  rr_sel;
  logic [GID_W-1:0]  rr_idx;
  logic              rr_hit;
  logic [CNT_W-1:0]  pix_cnt;
  logic [DATA_W-1:0] pack_reg;
  logic [DATA_W-1:0] out_reg;
  logic [DATA_W-1:0] word_next;
  logic              out_full;
  logic              cur_valid;
  logic              cur_last;
  logic [PIX_W-1:0]  cur_data;
  logic              can_load;
  logic              accept;
  logic              close_word;
  logic              drain;

  // Scan from the highest offset down so the requester closest to rr_ptr wins
  always_comb begin
    rr_sel = rr_ptr;
    rr_idx = rr_ptr;
    rr_hit = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      rr_idx = GID_W'((int'(rr_ptr) + i) % N_REQ);
      if (bus.req_valid[rr_idx]) begin
        rr_sel = rr_idx;
        rr_hit = 1'b1;
      end
    end
  end

  assign cur_valid  = bus.req_valid[grant_id];
  assign cur_last   = bus.req_last[grant_id];
  assign cur_data   = bus.req_data[grant_id*PIX_W +: PIX_W];
  assign can_load   = !out_full || bus.fifo_wr_vld;
  assign accept     = (state == XFER) && cur_valid && can_load;
  assign close_word = accept && (cur_last || (pix_cnt == CNT_W'(PIX_PER_WORD - 1)));
  assign drain      = out_full && bus.fifo_wr_vld;

  always_comb begin
    word_next = pack_reg;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      if (pix_cnt == CNT_W'(k)) word_next[k*PIX_W +: PIX_W] = cur_data;
    end
  end

  // Handshakes are masked during reset so nothing moves on the reset edge
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && (state == XFER)) bus.req_ready[grant_id] = can_load;
  end

  assign bus.grant_id     = grant_id;
  assign bus.busy         = (state != IDLE);
  assign bus.fifo_wr_en   = rst_n && drain;
  assign bus.fifo_wr_data = out_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      pix_cnt  <= '0;
      pack_reg <= '0;
      out_reg  <= '0;
      out_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rr_hit) begin
            grant_id <= rr_sel;
            state    <= XFER;
          end
        end
        XFER: begin
          if (accept && cur_last) state <= DRAIN;
        end
        DRAIN: begin
          if (!out_full || drain) begin
            rr_ptr <= GID_W'((int'(grant_id) + 1) % N_REQ);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        if (close_word) begin
          out_reg  <= word_next;
          pack_reg <= '0;
          pix_cnt  <= '0;
        end else begin
          pack_reg <= word_next;
          pix_cnt  <= pix_cnt + 1'b1;
        end
      end

      // A load in the same cycle as a drain keeps the register full
      if (close_word)  out_full <= 1'b1;
      else if (drain)  out_full <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pix_buff_wr_sched.sv
// Directed bench for pix_buff_wr_sched: line packing, flush, round-robin,
// backpressure and reset behaviour against hand-built expected words.
module tb_pix_buff_wr_sched;
  localparam int N_REQ  = 2;
  localparam int PIX_W  = 24;
  localparam int PPW    = 10;
  localparam int DATA_W = 240;

  typedef logic [DATA_W-1:0] word_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pix_buff_wr_sched_if #(.N_REQ(N_REQ), .PIX_W(PIX_W), .PIX_PER_WORD(PPW), .DATA_W(DATA_W)) bus();

  pix_buff_wr_sched #(.N_REQ(N_REQ), .PIX_W(PIX_W), .PIX_PER_WORD(PPW), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_total = 0;
  word_t wr_q[$];
  int    wr_gnt_q[$];
  int    wr_cyc_q[$];
  int    acc_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: samples late in the low phase, after all drives settle
  initial forever begin
    @(negedge clk);
    #3;
    if (bus.fifo_wr_en === 1'b1) begin
      wr_q.push_back(bus.fifo_wr_data);
      wr_gnt_q.push_back(int'(bus.grant_id));
      wr_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input word_t obs, input word_t expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  function automatic word_t make_word(input int base, input int cnt);
    word_t w = '0;
    for (int k = 0; k < cnt; k++) w[k*PIX_W +: PIX_W] = PIX_W'(base + k);
    return w;
  endfunction

  function automatic word_t wr_at(input int i);
    if (i < wr_q.size()) return wr_q[i];
    return 'x;
  endfunction

  task automatic clear_logs();
    wr_q.delete();
    wr_gnt_q.delete();
    wr_cyc_q.delete();
    acc_cyc_q.delete();
    acc_total = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid   = '0;
    bus.req_last    = '0;
    bus.fifo_wr_vld = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pixel values are base, base+1, ...; called just after a falling edge
  task automatic send_line(input int r, input int n, input int base, input bit with_last);
    int  k = 0;
    int  guard = 0;
    bit  acc;
    while (k < n && guard < 300) begin
      bus.req_valid[r] = 1'b1;
      bus.req_data[r*PIX_W +: PIX_W] = PIX_W'(base + k);
      bus.req_last[r]  = with_last && (k == n - 1);
      #1;
      acc = bus.req_ready[r];
      if (acc) begin
        acc_total++;
        acc_cyc_q.push_back(cyc);
      end
      @(negedge clk);
      if (acc) k++;
      guard++;
    end
    bus.req_valid[r] = 1'b0;
    bus.req_last[r]  = 1'b0;
    if (k < n) check("line_timeout", word_t'(k), word_t'(n));
  endtask

  task automatic wait_idle(output int at_cyc);
    int g = 0;
    while (bus.busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (bus.busy) check("idle_timeout", word_t'(1), word_t'(0));
    at_cyc = cyc;
  endtask

  initial begin
    int busy_cyc;
    rst_n = 1'b0;
    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.req_last    = '0;
    bus.fifo_wr_vld = 1'b1;

    // Reset state with both requesters asking
    bus.req_valid = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",   word_t'(bus.req_ready),  '0);
    check("rst_wr_en",   word_t'(bus.fifo_wr_en), '0);
    check("rst_wr_data", bus.fifo_wr_data,        '0);
    check("rst_busy",    word_t'(bus.busy),       '0);
    check("rst_grant",   word_t'(bus.grant_id),   '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_grant",   word_t'(bus.grant_id),   '0);
    check("rel_busy",    word_t'(bus.busy),       word_t'(1));
    bus.req_valid = '0;

    // Full-rate 20-pixel line
    do_reset();
    clear_logs();
    send_line(0, 20, 1, 1'b1);
    wait_idle(busy_cyc);
    check("fr_count", word_t'(wr_q.size()), word_t'(2));
    check("fr_word0", wr_at(0), make_word(1, 10));
    check("fr_word1", wr_at(1), make_word(11, 10));
    if (wr_cyc_q.size() >= 2 && acc_cyc_q.size() >= 20) begin
      check("fr_lat0",      word_t'(wr_cyc_q[0]), word_t'(acc_cyc_q[9] + 1));
      check("fr_lat1",      word_t'(wr_cyc_q[1]), word_t'(acc_cyc_q[19] + 1));
      check("fr_busy_fall", word_t'(busy_cyc),    word_t'(wr_cyc_q[1] + 1));
    end

    // 13-pixel line: zero-padded flush
    do_reset();
    clear_logs();
    send_line(0, 13, 1, 1'b1);
    wait_idle(busy_cyc);
    check("pf_count", word_t'(wr_q.size()), word_t'(2));
    check("pf_word0", wr_at(0), make_word(1, 10));
    check("pf_word1", wr_at(1), make_word(11, 3));
    begin
      word_t w1;
      w1 = wr_at(1);
      check("pf_upper", word_t'(w1[239:72]), '0);
    end

    // Round-robin with both requesters streaming back-to-back lines
    do_reset();
    clear_logs();
    fork
      begin send_line(0, 10, 'h100, 1'b1); send_line(0, 10, 'h300, 1'b1); end
      begin send_line(1, 10, 'h200, 1'b1); send_line(1, 10, 'h400, 1'b1); end
    join
    wait_idle(busy_cyc);
    check("rr_count", word_t'(wr_q.size()), word_t'(4));
    for (int i = 0; i < 4; i++) begin
      int exp_gnt;
      int exp_base;
      exp_gnt  = i % 2;
      exp_base = 'h100 * (i + 1);
      check($sformatf("rr_word%0d", i), wr_at(i), make_word(exp_base, 10));
      if (i < wr_gnt_q.size())
        check($sformatf("rr_grant%0d", i), word_t'(wr_gnt_q[i]), word_t'(exp_gnt));
    end

    // Backpressure for 5 cycles right after the first word closes
    do_reset();
    clear_logs();
    fork
      send_line(0, 20, 1, 1'b1);
      begin
        int g = 0;
        int rdy_hits = 0;
        int en_hits = 0;
        int chg = 0;
        word_t held;
        while (acc_total < 10 && g < 200) begin
          @(negedge clk);
          #2;
          g++;
        end
        @(negedge clk);
        bus.fifo_wr_vld = 1'b0;
        for (int c = 0; c < 5; c++) begin
          #2;
          if (bus.req_ready[0]) rdy_hits++;
          if (bus.fifo_wr_en)   en_hits++;
          if (c == 0) held = bus.fifo_wr_data;
          else if (bus.fifo_wr_data !== held) chg++;
          @(negedge clk);
        end
        bus.fifo_wr_vld = 1'b1;
        check("bp_ready_low", word_t'(rdy_hits), '0);
        check("bp_no_write",  word_t'(en_hits),  '0);
        check("bp_stable",    word_t'(chg),      '0);
        check("bp_held",      held,              make_word(1, 10));
      end
    join
    wait_idle(busy_cyc);
    check("bp_count", word_t'(wr_q.size()), word_t'(2));
    check("bp_word0", wr_at(0), make_word(1, 10));
    check("bp_word1", wr_at(1), make_word(11, 10));

    // Reset after 7 of 10 pixels
    do_reset();
    clear_logs();
    send_line(0, 7, 'h20, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mr_no_write", word_t'(wr_q.size()), '0);

    // Reset while a closed word is still waiting in the output register
    bus.fifo_wr_vld = 1'b0;
    send_line(0, 10, 'h70, 1'b0);
    rst_n = 1'b0;
    bus.fifo_wr_vld = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mr_pending_drop", word_t'(wr_q.size()), '0);

    send_line(0, 10, 'h50, 1'b1);
    wait_idle(busy_cyc);
    check("mr_count", word_t'(wr_q.size()), word_t'(1));
    check("mr_word",  wr_at(0), make_word('h50, 10));
    if (wr_gnt_q.size() > 0) check("mr_grant", word_t'(wr_gnt_q[0]), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
